// File: rtl/weight_pixel_mac.sv
// Weight x pixel multiply-accumulate with bias add, producing a signed score
// and a cat / not-cat decision. Every add saturates to the ACC_W range.
module weight_pixel_mac #(
    parameter int unsigned WEIGHT_W   = 6,
    parameter int unsigned PIXEL_W    = 8,
    parameter int unsigned NUM_INPUTS = 16,
    parameter int unsigned ACC_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [PIXEL_W-1:0]  pixel,
    input  logic [ACC_W-1:0]    bias,
    output logic                busy,
    output logic                done,
    output logic [ACC_W-1:0]    result,
    output logic                is_cat
);

    localparam int unsigned ProdW = WEIGHT_W + PIXEL_W + 1;
    localparam int unsigned CntW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned ExtW  = ACC_W + 1 - ProdW;

    localparam logic [CntW-1:0]  LastCount = CntW'(NUM_INPUTS - 1);
    localparam logic [ACC_W-1:0] AccMax    = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin    = {1'b1, {(ACC_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StBias,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              is_cat_q, is_cat_d;

    logic signed [ProdW-1:0] product;
    logic [ACC_W:0]          addend;
    logic [ACC_W:0]          sum_wide;
    logic [ACC_W-1:0]        sum_sat;
    logic                    beat;

    // Pixel is unsigned: a zero MSB keeps it non-negative in the signed multiply.
    assign product = $signed(weight) * $signed({1'b0, pixel});

    always_comb begin
        addend = {{ExtW{product[ProdW-1]}}, product};
        if (state_q == StBias) begin
            addend = {bias[ACC_W-1], bias};
        end
        sum_wide = {acc_q[ACC_W-1], acc_q} + addend;
        // One guard bit: top two bits disagreeing means the add left the range.
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sat = sum_wide[ACC_W] ? AccMin : AccMax;
        end else begin
            sum_sat = sum_wide[ACC_W-1:0];
        end
    end

    assign beat = (state_q == StAccum) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            is_cat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            is_cat_q <= is_cat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        is_cat_d = is_cat_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d = StAccum;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            StAccum: begin
                if (beat) begin
                    acc_d   = sum_sat;
                    count_d = count_q + CntW'(1);
                    if (count_q == LastCount) begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                acc_d    = sum_sat;
                result_d = sum_sat;
                is_cat_d = !sum_sat[ACC_W-1] && (|sum_sat);
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StAccum);
        busy     = (state_q == StAccum) || (state_q == StBias);
        done     = (state_q == StDone);
        result   = result_q;
        is_cat   = is_cat_q;
    end

endmodule
